// File: rtl/load_store_unit_pkg.sv
// mips_mem_pkg: shared definitions for the load/store unit.
//   - Opcode encodings OP_LB..OP_SW (MIPS I memory-op primary opcodes).
//   - FSM state enum, access-size encoding, and default parameters.
//   - op_size(): maps an opcode to its access size (ILLEGAL for non-memory ops).
// No ports (package only).
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int DEF_MEM_DEPTH   = 256;
    localparam int DEF_MEM_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } lsu_state_t;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } acc_size_t;

    function automatic acc_size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = HALF;
            OP_LW, OP_SW:         op_size = WORD;
            default:              op_size = ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// mem_lane_align: combinational byte-lane steering shared by the load and
// read-modify-write paths.
//   i_opcode   : latched memory opcode
//   i_lane     : byte address bits [1:0]
//   i_old_word : word read from memory
//   i_wdata    : store data (rt)
//   o_merged   : old word with the store bytes inserted (sb/sh), or i_wdata (sw)
//   o_load     : extracted and sign/zero-extended load data
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_old_word[{i_lane, 3'b000} +: 8];
    // Halfword selection uses only addr[1]; addr[0] is dropped when misaligned
    // accesses are allowed to proceed.
    assign w_half = i_lane[1] ? i_old_word[31:16] : i_old_word[15:0];

    always_comb begin
        o_merged = i_old_word;
        o_load   = i_old_word;
        case (i_opcode)
            OP_LB:  o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU: o_load = {24'h0, w_byte};
            OP_LH:  o_load = {{16{w_half[15]}}, w_half};
            OP_LHU: o_load = {16'h0, w_half};
            OP_SB:  o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
            OP_SH: begin
                if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
                else           o_merged[15:0]  = i_wdata[15:0];
            end
            OP_SW:  o_merged = i_wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one data-memory access per request between the
// EX stage and a word-indexed data memory.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_opcode/req_addr/req_wdata   memory opcode, byte address, store data
//   mem_address/mem_write_data      word index and write word to memory
//   mem_opcode                      constant full-word op (0x2B)
//   MemRead/MemWrite                memory strobes, each held MEM_LATENCY cycles
//   mem_read_data                   word returned by memory
//   resp_valid/resp_ready           response handshake
//   resp_rdata/resp_exc             extended load data (0 for stores), fault flag
// Build option: MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses fault; otherwise the low address bits are truncated.
//
// state  | meaning
// IDLE   | waiting for a request; fault check on accept
// RD     | load: MemRead for MEM_LATENCY cycles, sample on the last
// WR     | sw: MemWrite for MEM_LATENCY cycles
// RMW_RD | sb/sh: read old word for MEM_LATENCY cycles
// RMW_WR | one idle gap cycle, then MemWrite of merged word for MEM_LATENCY cycles
// RESP   | resp_valid held until resp_ready
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_opcode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [5:0]  mem_opcode,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] mem_read_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_exc
);

    localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] LAT_GAP  = 4'(MEM_LATENCY);

    lsu_state_t  r_state, w_next;
    logic [5:0]  r_op;
    logic [31:0] r_addr, r_wdata, r_rdata, r_resp_rdata;
    logic        r_exc;
    logic [3:0]  r_cnt;

    logic        w_accept, w_last, w_fault, w_range;
    acc_size_t   w_size;
    logic [31:0] w_old, w_merged, w_load;

    assign w_accept = req_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == 4'd0);
    assign w_size   = op_size(req_opcode);
    assign w_range  = {2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH);

`ifdef MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_size == HALF) && req_addr[0]) ||
                        ((w_size == WORD) && (req_addr[1:0] != 2'b00));
    assign w_fault    = (w_size == ILLEGAL) || w_range || w_misalign;
`else
    assign w_fault    = (w_size == ILLEGAL) || w_range;
`endif

    // Read states steer the live memory word; RMW_WR merges into the saved copy.
    assign w_old = ((r_state == RD) || (r_state == RMW_RD)) ? mem_read_data : r_rdata;

    mem_lane_align u_align (
        .i_opcode   (r_op),
        .i_lane     (r_addr[1:0]),
        .i_old_word (w_old),
        .i_wdata    (r_wdata),
        .o_merged   (w_merged),
        .o_load     (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_fault)                                      w_next = RESP;
                    else if (req_opcode == OP_SW)                     w_next = WR;
                    else if (req_opcode == OP_SB || req_opcode == OP_SH) w_next = RMW_RD;
                    else                                              w_next = RD;
                end
            end
            RD:      if (w_last) w_next = RESP;
            WR:      if (w_last) w_next = RESP;
            RMW_RD:  if (w_last) w_next = RMW_WR;
            RMW_WR:  if (w_last) w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (r_state == IDLE);
        resp_valid     = (r_state == RESP);
        MemRead        = (r_state == RD) || (r_state == RMW_RD);
        MemWrite       = 1'b0;
        mem_write_data = 32'h0;
        case (r_state)
            WR: begin
                MemWrite       = 1'b1;
                mem_write_data = r_wdata;
            end
            RMW_WR: begin
                // First RMW_WR cycle (counter still at reload value) is the gap.
                MemWrite       = (r_cnt != LAT_GAP);
                mem_write_data = w_merged;
            end
            default: ;
        endcase
    end

    assign mem_address = {2'b00, r_addr[31:2]};
    assign mem_opcode  = OP_SW;
    assign resp_rdata  = r_resp_rdata;
    assign resp_exc    = r_exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= 6'h0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_rdata      <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_exc        <= 1'b0;
            r_cnt        <= 4'h0;
        end else if (w_accept) begin
            r_op         <= req_opcode;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            r_exc        <= w_fault;
            r_resp_rdata <= 32'h0;
            r_cnt        <= LAT_LAST;
        end else begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (r_state == RD && w_last) r_resp_rdata <= w_load;
            if (r_state == RMW_RD && w_last) begin
                r_rdata <= mem_read_data;
                r_cnt   <= LAT_GAP;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;

    logic        clk, rst_n;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_exc;
    logic [5:0]  req_opcode, mem_opcode;
    logic [31:0] req_addr, req_wdata, mem_address, mem_write_data, mem_read_data, resp_rdata;
    logic        MemRead, MemWrite;

    load_store_unit #(.MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_opcode(mem_opcode),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_read_data(mem_read_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_exc(resp_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural memory seen by the DUT, plus the reference copy the model updates.
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        preload;

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_word(i);
        end else if (MemWrite && mem_address < 32'(DEPTH)) begin
            mem[mem_address[7:0]] <= mem_write_data;
        end
    end
    assign mem_read_data = (mem_address < 32'(DEPTH)) ? mem[mem_address[7:0]] : 32'hBAD0BAD0;

    // Reference model: access size, shift and mask arithmetic on a word array.
    task automatic model(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output bit exc, output logic [31:0] rdata,
                         output int lat, output int nrd, output int nwr);
        int          size, off;
        bit          legal, is_load, sgn;
        logic [31:0] idx, old, mask, val;
        legal = 1; is_load = 0; sgn = 0; size = 4;
        case (op)
            6'h20: begin size = 1; is_load = 1; sgn = 1; end
            6'h21: begin size = 2; is_load = 1; sgn = 1; end
            6'h23: begin size = 4; is_load = 1; end
            6'h24: begin size = 1; is_load = 1; end
            6'h25: begin size = 2; is_load = 1; end
            6'h28: size = 1;
            6'h29: size = 2;
            6'h2B: size = 4;
            default: legal = 0;
        endcase
        idx = addr >> 2;
        exc = !legal || (idx >= 32'(DEPTH));
`ifdef MISALIGN_TRAP_EN
        if ((addr % 32'(size)) != 0) exc = 1;
`endif
        rdata = 32'h0; lat = 1; nrd = 0; nwr = 0;
        if (!exc) begin
            old  = ref_mem[idx[7:0]];
            off  = (size == 1) ? 8 * int'(addr % 4) : (size == 2) ? 16 * int'((addr % 4) / 2) : 0;
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
            if (is_load) begin
                val = (old >> off) & mask;
                if (sgn && val[8 * size - 1]) val = val | ~mask;
                rdata = val;
                lat   = LAT + 1;
                nrd   = LAT;
            end else begin
                ref_mem[idx[7:0]] = (old & ~(mask << off)) | ((wd & mask) << off);
                nwr = LAT;
                if (size == 4) lat = LAT + 1;
                else begin lat = 2 * LAT + 2; nrd = LAT; end
            end
        end
    endtask

    task automatic do_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int hold, output logic [31:0] got);
        bit          e_exc, done, prev_rd;
        logic [31:0] e_rd, idx;
        int          e_lat, e_nrd, e_nwr, cyc, nrd, nwr, bad;
        model(op, addr, wd, e_exc, e_rd, e_lat, e_nrd, e_nwr);
        idx = {2'b00, addr[31:2]};
        @(negedge clk);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_opcode = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_opcode = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
        done = 0; prev_rd = 0; cyc = 0; nrd = 0; nwr = 0; bad = 0;
        for (int c = 1; c <= 100 && !done; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                done = 1; cyc = c;
            end else begin
                if (MemRead) nrd++;
                if (MemWrite) nwr++;
                if (MemRead && MemWrite) bad++;
                if (prev_rd && MemWrite) bad++;
                if ((MemRead || MemWrite) && mem_address != idx) bad++;
                prev_rd = MemRead;
            end
        end
        if (!done) begin
            check("resp_timeout", 32'(cyc), 32'(e_lat));
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "response never arrived, aborting");
        end
        check("latency", 32'(cyc), 32'(e_lat));
        check("resp_exc", {31'b0, resp_exc}, {31'b0, e_exc});
        check("resp_rdata", resp_rdata, e_rd);
        check("read_cycles", 32'(nrd), 32'(e_nrd));
        check("write_cycles", 32'(nwr), 32'(e_nwr));
        check("strobe_rules", 32'(bad), 32'd0);
        got = resp_rdata;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, e_rd);
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check("post_resp_valid", {31'b0, resp_valid}, 32'd0);
        if (idx < 32'(DEPTH)) check("mem_word", mem[idx[7:0]], ref_mem[idx[7:0]]);
    endtask

    logic [5:0] op_tab [9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h22};

    initial begin
        logic [31:0] got, a;
        rst_n = 1'b0; preload = 1'b1; resp_ready = 1'b0;
        req_valid = 1'b0; req_opcode = 6'h0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_exc", {31'b0, resp_exc}, 32'd0);
        check("rst_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_opcode", {26'b0, mem_opcode}, 32'h2B);
        rst_n = 1'b1;

        do_op(6'h2B, 32'h34, 32'hDEADBEEF, 0, got);
        check("sw_word13", mem[13], 32'hDEADBEEF);
        do_op(6'h28, 32'h35, 32'h000000FD, 0, got);
        check("sb_word13", mem[13], 32'hDEADFDEF);
        do_op(6'h20, 32'h35, 32'h0, 0, got);
        check("lb_const", got, 32'hFFFFFFFD);
        do_op(6'h24, 32'h35, 32'h0, 0, got);
        check("lbu_const", got, 32'h000000FD);
        do_op(6'h25, 32'h36, 32'h0, 0, got);
        check("lhu_const", got, 32'h0000DEAD);
        do_op(6'h23, 32'h36, 32'h0, 0, got);
`ifdef MISALIGN_TRAP_EN
        check("lw_misaligned", got, 32'h0);
`else
        check("lw_truncated", got, 32'hDEADFDEF);
`endif
        do_op(6'h2B, 32'h400, 32'h12345678, 0, got);
        do_op(6'h22, 32'h10, 32'h0, 0, got);
        do_op(6'h29, 32'h3A, 32'hCAFEBABE, 0, got);
        do_op(6'h21, 32'h3A, 32'h0, 5, got);

        // Reset in the second WR cycle: strobe must drop without waiting for a clock.
        @(negedge clk);
        req_valid = 1'b1; req_opcode = 6'h2B; req_addr = 32'h50; req_wdata = 32'h0BADF00D;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wr_cycle2_strobe", {31'b0, MemWrite}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("rst_drops_write", {31'b0, MemWrite}, 32'd0);
        ref_mem[20] = 32'h0BADF00D;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("post_rst_mem20", mem[20], ref_mem[20]);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 7) == 0) a = {$urandom_range(32'h100, 32'h3FFF_FFFF), 2'($urandom)};
            else                           a = {22'h0, 8'($urandom_range(0, 31)), 2'($urandom)};
            do_op(op_tab[$urandom_range(0, 8)], a, $urandom, $urandom_range(0, 3), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
